// File: rtl/pixel_serializer_pkg.sv
// Shared parameters, state type and byte-selection helpers for the pixel serializer.
// Pixels are at most MAX_PIXEL_BITS wide; RGB pixels leave as three bytes, MSB first.
package pixel_serializer_pkg;

    localparam int         MAX_PIXEL_BITS   = 24;
    localparam int         BYTES_PER_RGB_PX = 3;
    localparam logic [1:0] SEL_RGB          = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_e;

    // Number of bytes an entry produces on the output.
    function automatic logic [1:0] px_bytes(input logic is_rgb);
        px_bytes = is_rgb ? 2'(BYTES_PER_RGB_PX) : 2'd1;
    endfunction

    // Byte idx of a pixel, idx 0 = bits [7:0].
    function automatic logic [7:0] pick_byte(input logic [MAX_PIXEL_BITS-1:0] px,
                                             input logic [1:0]                idx);
        case (idx)
            2'd2:    pick_byte = px[23:16];
            2'd1:    pick_byte = px[15:8];
            default: pick_byte = px[7:0];
        endcase
    endfunction

endpackage

// File: rtl/pixel_serializer_px_fifo.sv
// Pixel entry FIFO: synchronous push/pop, extra pointer bit separates full from empty.
// A push while full is accepted only when a pop happens on the same edge; otherwise drop_o flags it.
module px_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 25
) (
    input  logic             clk_i,
    input  logic             nreset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             drop_o
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign drop_o  = push_i && !do_push;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/pixel_serializer.sv
// Buffers pixels from the processing pipeline and emits them as a byte stream
// with valid/ack flow control: byte_o moves on every edge where byte_vld_o and byte_ack_i are both high.
import pixel_serializer_pkg::*;

module pixel_serializer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      nreset_i,
    input  logic [1:0]                select_i,
    input  logic                      px_rdy_i,
    input  logic [MAX_PIXEL_BITS-1:0] in_pixel_i,
    output logic [7:0]                byte_o,
    output logic                      byte_vld_o,
    input  logic                      byte_ack_i,
    output logic                      busy_o,
    output logic                      overflow_o
);

    ser_state_e                state_q, state_d;
    logic [MAX_PIXEL_BITS-1:0] ent_px_q, ent_px_d;
    logic [1:0]                cnt_q, cnt_d;
    logic [7:0]                byte_q, byte_d;
    logic                      vld_q, vld_d;
    logic                      ovf_q, ovf_d;

    logic [MAX_PIXEL_BITS:0]   fifo_rdata;
    logic [MAX_PIXEL_BITS-1:0] rd_px;
    logic                      rd_rgb;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_drop;
    logic                      pop;
    logic                      slot_free;

    px_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (MAX_PIXEL_BITS + 1)
    ) u_fifo (
        .clk_i    (clk_i),
        .nreset_i (nreset_i),
        .push_i   (px_rdy_i),
        .wdata_i  ({in_pixel_i, select_i == SEL_RGB}),
        .pop_i    (pop),
        .rdata_o  (fifo_rdata),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .drop_o   (fifo_drop)
    );

    assign rd_px     = fifo_rdata[MAX_PIXEL_BITS:1];
    assign rd_rgb    = fifo_rdata[0];
    assign slot_free = !vld_q || byte_ack_i;

    // cnt_q holds how many bytes of the current entry are still to be loaded into byte_q.
    always_comb begin
        state_d  = state_q;
        ent_px_d = ent_px_q;
        cnt_d    = cnt_q;
        byte_d   = byte_q;
        vld_d    = vld_q;
        pop      = 1'b0;
        ovf_d    = ovf_q | fifo_drop;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    ent_px_d = rd_px;
                    cnt_d    = px_bytes(rd_rgb);
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (slot_free) begin
                    if (cnt_q != 2'd0) begin
                        byte_d = pick_byte(ent_px_q, cnt_q - 2'd1);
                        vld_d  = 1'b1;
                        cnt_d  = cnt_q - 2'd1;
                    end else if (!fifo_empty) begin
                        // Chain straight into the next entry so the stream has no gap.
                        pop      = 1'b1;
                        ent_px_d = rd_px;
                        byte_d   = pick_byte(rd_px, px_bytes(rd_rgb) - 2'd1);
                        vld_d    = 1'b1;
                        cnt_d    = px_bytes(rd_rgb) - 2'd1;
                    end else begin
                        vld_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q  <= ST_IDLE;
            ent_px_q <= '0;
            cnt_q    <= 2'd0;
            byte_q   <= 8'h00;
            vld_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ent_px_q <= ent_px_d;
            cnt_q    <= cnt_d;
            byte_q   <= byte_d;
            vld_q    <= vld_d;
            ovf_q    <= ovf_d;
        end
    end

    assign byte_o     = byte_q;
    assign byte_vld_o = vld_q;
    assign overflow_o = ovf_q;
    assign busy_o     = !fifo_empty || (state_q == ST_SEND);

endmodule

// File: tb/tb_pixel_serializer.sv
// Self-checking bench for pixel_serializer: directed scenarios plus a byte scoreboard
// fed at push time and drained by a negedge monitor on every accepted transfer.
module tb_pixel_serializer;

    logic        clk_i;
    logic        nreset_i;
    logic [1:0]  select_i;
    logic        px_rdy_i;
    logic [23:0] in_pixel_i;
    logic [7:0]  byte_o;
    logic        byte_vld_o;
    logic        byte_ack_i;
    logic        busy_o;
    logic        overflow_o;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[$];

    pixel_serializer #(.FIFO_DEPTH(4)) dut (
        .clk_i      (clk_i),
        .nreset_i   (nreset_i),
        .select_i   (select_i),
        .px_rdy_i   (px_rdy_i),
        .in_pixel_i (in_pixel_i),
        .byte_o     (byte_o),
        .byte_vld_o (byte_vld_o),
        .byte_ack_i (byte_ack_i),
        .busy_o     (busy_o),
        .overflow_o (overflow_o)
    );

    // clock / reset
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests_run, tests_failed);
        $fatal(1, "watchdog");
    end

    // scoreboard monitor: a transfer happens at the next rising edge
    always @(negedge clk_i) begin
        if (nreset_i && byte_vld_o && byte_ack_i) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_unexpected: got byte %02h, required no byte", byte_o);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (byte_o !== e) begin
                    tests_failed++;
                    $display("FAIL sb_byte: got %02h, required %02h", byte_o, e);
                end
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_push(input logic [1:0] sel, input logic [23:0] px, input bit accept);
        logic [23:0] p;
        p          = px;
        select_i   = sel;
        in_pixel_i = p;
        px_rdy_i   = 1'b1;
        if (accept) begin
            if (sel == 2'b11) begin
                exp_q.push_back(p[23:16]);
                exp_q.push_back(p[15:8]);
                exp_q.push_back(p[7:0]);
            end else begin
                exp_q.push_back(p[7:0]);
            end
        end
        tick();
        px_rdy_i = 1'b0;
    endtask

    task automatic apply_reset();
        nreset_i = 1'b0;
        exp_q.delete();
        tick();
        tick();
        nreset_i = 1'b1;
        tick();
    endtask

    task automatic wait_drain(input bit rand_ack, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            if (rand_ack) byte_ack_i = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        byte_ack_i = 1'b1;
        tick();
        tick();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_drain: %0d bytes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // scenarios
    task automatic test_reset();
        nreset_i = 1'b0;
        #1;
        tests_run++;
        if (byte_o !== 8'h00 || byte_vld_o !== 1'b0 || busy_o !== 1'b0 || overflow_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: got byte=%02h vld=%b busy=%b ovf=%b, required 00 0 0 0",
                     byte_o, byte_vld_o, busy_o, overflow_o);
        end
        tick();
        tick();
        nreset_i = 1'b1;
        tick();
    endtask

    task automatic test_single();
        byte_ack_i = 1'b1;
        drive_push(2'b00, 24'h0000A5, 1'b1);
        tests_run++;
        if (byte_vld_o !== 1'b0 || busy_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_edge1: got vld=%b busy=%b, required 0 1", byte_vld_o, busy_o);
        end
        tick();
        tests_run++;
        if (byte_vld_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_edge2: got vld=%b, required 0", byte_vld_o);
        end
        tick();
        tests_run++;
        if (byte_vld_o !== 1'b1 || byte_o !== 8'hA5) begin
            tests_failed++;
            $display("FAIL single_latency: got vld=%b byte=%02h, required 1 a5", byte_vld_o, byte_o);
        end
        tick();
        tests_run++;
        if (byte_vld_o !== 1'b0 || busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_after: got vld=%b busy=%b, required 0 0", byte_vld_o, busy_o);
        end
        wait_drain(1'b0, "single");
    endtask

    task automatic test_rgb();
        logic [7:0] want [3];
        want[0] = 8'h12;
        want[1] = 8'h34;
        want[2] = 8'h56;
        byte_ack_i = 1'b1;
        drive_push(2'b11, 24'h123456, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (byte_vld_o !== 1'b1 || byte_o !== want[i]) begin
                tests_failed++;
                $display("FAIL rgb_byte%0d: got vld=%b byte=%02h, required 1 %02h",
                         i, byte_vld_o, byte_o, want[i]);
            end
        end
        tick();
        tests_run++;
        if (byte_vld_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rgb_end: got vld=%b, required 0", byte_vld_o);
        end
        wait_drain(1'b0, "rgb");
    endtask

    task automatic test_hold();
        byte_ack_i = 1'b0;
        drive_push(2'b01, 24'h0000C3, 1'b1);
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            if (i == 5) byte_ack_i = 1'b1;
            tests_run++;
            if (byte_vld_o !== 1'b1 || byte_o !== 8'hC3) begin
                tests_failed++;
                $display("FAIL hold_cycle%0d: got vld=%b byte=%02h, required 1 c3", i, byte_vld_o, byte_o);
            end
            if (i < 5) tick();
        end
        tick();
        tests_run++;
        if (byte_vld_o !== 1'b0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL hold_single: got vld=%b pending=%0d, required 0 0", byte_vld_o, exp_q.size());
        end
        wait_drain(1'b0, "hold");
    endtask

    task automatic test_mode_switch();
        byte_ack_i = 1'b1;
        drive_push(2'b11, 24'hAABBCC, 1'b1);
        drive_push(2'b10, 24'h000011, 1'b1);
        wait_drain(1'b0, "mode_switch");
    endtask

    task automatic test_back_to_back();
        int run;
        byte_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) drive_push(2'b11, 24'($urandom), 1'b1);
        run = 0;
        for (int i = 0; i < 9; i++) begin
            if (byte_vld_o === 1'b1) run++;
            tick();
        end
        tests_run++;
        if (run != 9 || byte_vld_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_stream: got %0d valid cycles, trailing vld=%b, required 9 0", run, byte_vld_o);
        end
        wait_drain(1'b0, "b2b");
    endtask

    task automatic test_random();
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < 3; i++) begin
                byte_ack_i = 1'($urandom_range(0, 1));
                drive_push(2'($urandom_range(0, 3)), 24'($urandom), 1'b1);
                for (int g = $urandom_range(0, 2); g > 0; g--) begin
                    byte_ack_i = 1'($urandom_range(0, 1));
                    tick();
                end
            end
            wait_drain(1'b1, "random");
        end
        tests_run++;
        if (overflow_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL random_ovf: got %b, required 0", overflow_o);
        end
    endtask

    task automatic test_overflow();
        byte_ack_i = 1'b0;
        for (int i = 1; i <= 5; i++) drive_push(2'b00, 24'(i), 1'b1);
        tests_run++;
        if (overflow_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_fill: got %b, required 0", overflow_o);
        end
        drive_push(2'b00, 24'h000066, 1'b0);
        tests_run++;
        if (overflow_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_set: got %b, required 1", overflow_o);
        end
        byte_ack_i = 1'b1;
        wait_drain(1'b0, "ovf");
        for (int i = 0; i < 4; i++) tick();
        tests_run++;
        if (overflow_o !== 1'b1 || busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_sticky: got ovf=%b busy=%b, required 1 0", overflow_o, busy_o);
        end
    endtask

    task automatic test_full_push_pop();
        apply_reset();
        byte_ack_i = 1'b0;
        for (int i = 1; i <= 5; i++) drive_push(2'b00, 24'(8'hA0 + i), 1'b1);
        byte_ack_i = 1'b1;
        drive_push(2'b00, 24'h0000A6, 1'b1);
        tests_run++;
        if (overflow_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_push_pop: got ovf=%b, required 0", overflow_o);
        end
        wait_drain(1'b0, "full_push_pop");
    endtask

    task automatic test_reset_mid();
        int seen;
        byte_ack_i = 1'b1;
        drive_push(2'b11, 24'hAABBCC, 1'b1);
        tick();
        tick();
        tick();
        nreset_i = 1'b0;
        exp_q.delete();
        #1;
        tests_run++;
        if (byte_vld_o !== 1'b0 || busy_o !== 1'b0 || byte_o !== 8'h00) begin
            tests_failed++;
            $display("FAIL rst_mid_async: got vld=%b busy=%b byte=%02h, required 0 0 00",
                     byte_vld_o, busy_o, byte_o);
        end
        tick();
        nreset_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (byte_vld_o !== 1'b0) seen++;
            tick();
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("FAIL rst_mid_quiet: got %0d valid cycles after release, required 0", seen);
        end
    endtask

    initial begin
        nreset_i   = 1'b0;
        select_i   = 2'b00;
        px_rdy_i   = 1'b0;
        in_pixel_i = 24'h0;
        byte_ack_i = 1'b0;
        tick();
        test_reset();
        test_single();
        test_rgb();
        test_hold();
        test_mode_switch();
        test_back_to_back();
        test_random();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pixel_serializer.md
PIXEL_SERIALIZER -- requirements
Module: pixel_serializer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of buffered pixel entries (power of two, >=2).
REQ-002 SHALL have port clk_i  input  1  single clock; all flops rise-edge triggered.
REQ-003 SHALL have port nreset_i  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port select_i  input  2  pipeline mode; 2'b11 = bypass (RGB), others = single-byte pixel.
REQ-005 SHALL have port px_rdy_i  input  1  one-cycle strobe; in_pixel_i valid this cycle.
REQ-006 SHALL have port in_pixel_i  input  MAX_PIXEL_BITS  pixel from processing pipeline output.
REQ-007 SHALL have port byte_o  output  8  serialized output byte.
REQ-008 SHALL have port byte_vld_o  output  1  byte_o valid, held until acknowledged.
REQ-009 SHALL have port byte_ack_i  input  1  consumer accepts byte_o when high with byte_vld_o.
REQ-010 SHALL have port busy_o  output  1  FIFO non-empty or byte transfer in progress.
REQ-011 SHALL have port overflow_o  output  1  sticky flag: a pixel was dropped.

Function
REQ-012 On px_rdy_i high at an edge and FIFO not full, SHALL push {in_pixel_i, is_rgb} where is_rgb = (select_i==2'b11) sampled that edge.
REQ-013 Bytes per entry SHALL be 3 when is_rgb=1, order [23:16], [15:8], [7:0]; else 1, value [7:0].
REQ-014 FSM states SHALL be IDLE and SEND; IDLE->SEND when FIFO non-empty (pop entry, load byte counter); SEND->IDLE after last byte acked and FIFO empty; SEND->SEND (pop next) after last byte acked and FIFO non-empty, no idle cycle.
REQ-015 byte_o and byte_vld_o SHALL be registered; byte_o SHALL be stable while byte_vld_o high and byte_ack_i low.
REQ-016 A byte SHALL transfer on each edge where byte_vld_o and byte_ack_i are both high; byte_ack_i while byte_vld_o low SHALL be ignored.
REQ-017 Latency: px_rdy_i sampled at edge k with FIFO empty and FSM IDLE SHALL give byte_vld_o high after edge k+2.
REQ-018 Continuous byte_ack_i high SHALL sustain one byte per cycle across entry boundaries.
REQ-019 Push when full SHALL drop the pixel and set overflow_o; overflow_o SHALL stay high until reset.
REQ-020 Simultaneous push and pop when full SHALL accept the push (no overflow).
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty via extra pointer bit.
REQ-022 select_i changes SHALL affect only subsequently pushed entries.
REQ-023 busy_o SHALL be combinational: FIFO non-empty OR state==SEND.

Reset
REQ-024 nreset_i low SHALL asynchronously clear: byte_o=8'h00, byte_vld_o=0, overflow_o=0, FIFO pointers=0, byte counter=0, state=IDLE; busy_o=0 follows.
REQ-025 Reset mid-transfer SHALL discard buffered and in-flight pixels; no byte emitted after release until a new push.

Structure
REQ-026 MAX_PIXEL_BITS and a new BYTES_PER_RGB_PX=3 SHALL come from the shared parameters package; state enum typedef SHALL live in that package.
REQ-027 Storage SHALL be a sub-module px_fifo (synchronous push/pop, full/empty, width MAX_PIXEL_BITS+1); FSM and byte mux in pixel_serializer.

Verification
REQ-028 Mode 2'b00, push 24'h0000A5, ack held high -> byte_vld_o high 2 edges after push, byte_o=8'hA5 for one cycle, busy_o low afterwards.
REQ-029 Mode 2'b11, push 24'h123456, ack held high -> bytes 8'h12, 8'h34, 8'h56 on consecutive cycles.
REQ-030 Push 24'h0000C3, ack low 5 cycles then high -> byte_o=8'hC3, byte_vld_o high for all 6 cycles, single transfer.
REQ-031 Ack low, push 5 pixels (FIFO_DEPTH=4) back-to-back -> first SEND-loaded, 4 buffered, nothing dropped, overflow_o=0; 6th push -> overflow_o=1 and dropped pixel never appears.
REQ-032 Mode 2'b11 push 24'hAABBCC, switch to 2'b10, push 24'h000011 -> output AA, BB, CC, 11.
REQ-033 nreset_i low mid-way through 24'hAABBCC (after AA) -> byte_vld_o=0 immediately; no BB/CC after release.
